// File: rtl/vec_seq_ctrl_if.sv
// Request/response bundle between decode and the vector sequencer.
// Decode drives the request side; the sequencer drives busy/done/result.
interface vec_seq_ctrl_if #(
    parameter int LANES = 16,
    parameter int W     = 16
);
    logic                 start;
    logic [3:0]           opcode;
    logic [LANES*W-1:0]   op_1;
    logic [LANES*W-1:0]   op_2;
    logic                 busy;
    logic                 done;
    logic [LANES*W-1:0]   result;

    // Handshake: start is a one-cycle request that is only taken while busy=0
    // and the opcode is VDOT/SMUL; there is no backpressure. done is a one-cycle
    // valid for result, and result then holds until the next accepted start.
    modport master (
        output start, opcode, op_1, op_2,
        input  busy, done, result
    );

    modport slave (
        input  start, opcode, op_1, op_2,
        output busy, done, result
    );
endinterface

// File: rtl/vec_seq_ctrl.sv
// Multi-cycle sequencer for VDOT/SMUL: walks one lane per clock through a
// shared external half-float multiplier and adder.
module vec_seq_ctrl #(
    parameter int LANES = 16,
    parameter int W     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    vec_seq_ctrl_if.slave bus,
    output logic [W-1:0]  mul_a,
    output logic [W-1:0]  mul_b,
    input  logic [W-1:0]  mul_p,
    output logic [W-1:0]  add_a,
    output logic [W-1:0]  add_b,
    input  logic [W-1:0]  add_s,
    output logic [1:0]    fsm_state
);
    localparam int VW = LANES * W;
    localparam int LW = $clog2(LANES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_VDOT = 4'b0001;
    localparam logic [3:0] OP_SMUL = 4'b0010;

    localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);

    logic [1:0]    state;
    logic [LW-1:0] lane;
    logic [W-1:0]  acc;
    logic [VW-1:0] a_reg;
    logic [VW-1:0] b_reg;
    logic [3:0]    op_reg;
    logic [VW-1:0] result_reg;

    logic op_ok;
    logic is_vdot;
    logic last_lane;

    assign op_ok     = (bus.opcode == OP_VDOT) || (bus.opcode == OP_SMUL);
    assign is_vdot   = (op_reg == OP_VDOT);
    assign last_lane = (lane == LANE_LAST);

    assign bus.busy   = (state != S_IDLE);
    assign bus.done   = (state == S_DONE);
    assign bus.result = result_reg;
    assign fsm_state  = state;

    // Shared units see zero operands outside RUN so their inputs stay quiet.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        add_a = '0;
        add_b = '0;
        if (state == S_RUN) begin
            mul_a = is_vdot ? a_reg[int'(lane)*W +: W] : a_reg[W-1:0];
            mul_b = b_reg[int'(lane)*W +: W];
            if (is_vdot) begin
                add_a = acc;
                add_b = mul_p;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            lane       <= '0;
            acc        <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= '0;
            result_reg <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start && op_ok) begin
                        a_reg      <= bus.op_1;
                        b_reg      <= bus.op_2;
                        op_reg     <= bus.opcode;
                        lane       <= '0;
                        acc        <= '0;
                        result_reg <= '0;
                        state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (is_vdot) begin
                        acc <= add_s;
                        // Publish the final sum so result is valid in DONE.
                        if (last_lane) begin
                            result_reg <= {{(VW-W){1'b0}}, add_s};
                        end
                    end else begin
                        result_reg[int'(lane)*W +: W] <= mul_p;
                    end
                    if (last_lane) begin
                        lane  <= '0;
                        state <= S_DONE;
                    end else begin
                        lane <= lane + LW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
